uart_rx: RTL



---
 rtl/uart_rx.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, idle-high line, oversampled by a
// shared baud_tick (OVS ticks per bit). Samples each bit near its centre.
// Ports:
//   clk, rst     - system clock, asynchronous active-high reset
//   baud_tick    - single-clk pulse, OVS per bit period
//   rx           - asynchronous serial input, idle high
//   o_rx_data    - last correctly received byte
//   o_rx_done    - one-clk pulse when o_rx_data is updated
//   o_rx_busy    - high while a frame is in progress
//   o_frame_err  - one-clk pulse when the stop bit is sampled low
module uart_rx #(
    parameter int unsigned OVS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic       rx,
    output logic [7:0] o_rx_data,
    output logic       o_rx_done,
    output logic       o_rx_busy,
    output logic       o_frame_err
);

    localparam int unsigned CW = $clog2(OVS);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(OVS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] b_cnt, b_cnt_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shift, shift_n;
    logic [7:0]    data_n;
    logic          done_n, err_n, busy_n;
    logic          rx_meta, rx_s;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            b_cnt       <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            o_rx_data   <= '0;
            o_rx_done   <= 1'b0;
            o_rx_busy   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            state       <= state_n;
            b_cnt       <= b_cnt_n;
            bit_cnt     <= bit_cnt_n;
            shift       <= shift_n;
            o_rx_data   <= data_n;
            o_rx_done   <= done_n;
            o_rx_busy   <= busy_n;
            o_frame_err <= err_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n   = state;
        b_cnt_n   = b_cnt;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        data_n    = o_rx_data;
        done_n    = 1'b0;
        err_n     = 1'b0;

        case (state)
            IDLE: begin
                b_cnt_n   = '0;
                bit_cnt_n = '0;
                if (!rx_s) begin
                    state_n = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    if (b_cnt == HALF_LAST) begin
                        // Mid start bit: a high line here was only a glitch.
                        b_cnt_n   = '0;
                        bit_cnt_n = '0;
                        state_n   = rx_s ? IDLE : DATA;
                    end else begin
                        b_cnt_n = b_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (b_cnt == BIT_LAST) begin
                        shift_n   = {rx_s, shift[7:1]};
                        b_cnt_n   = '0;
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_n = STOP;
                        end
                    end else begin
                        b_cnt_n = b_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (b_cnt == BIT_LAST) begin
                        b_cnt_n = '0;
                        if (rx_s) begin
                            data_n  = shift;
                            done_n  = 1'b1;
                            state_n = IDLE;
                        end else begin
                            err_n   = 1'b1;
                            state_n = BREAK;
                        end
                    end else begin
                        b_cnt_n = b_cnt + 1'b1;
                    end
                end
            end
            BREAK: begin
                // Wait for the line to return high so a held-low line
                // cannot be mistaken for a new start bit.
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule
